result_framer: RTL and testbench
================================

RESULT_FRAMER -- requirements
Module: result_framer

Interface
REQ-001 SHALL have parameter NUMPOSITIONS, default 5: index of the last mark; each ruler has NUMPOSITIONS+1 marks of 9 bits.
REQ-002 SHALL have parameter NUMRESULTS, default 10: number of result slots in the results vector.
REQ-003 SHALL have port FXCLK, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port RESET_IN, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port done, input, 1: search-complete level from the ruler search.
REQ-006 SHALL have port numResults, input, 6: count of equally-best rulers found.
REQ-007 SHALL have port results, input, (NUMPOSITIONS+1)*9*NUMRESULTS: slot 1 in the MSBs; within a slot, m[0] in the MSBs.
REQ-008 SHALL have port out_data, output, 8: byte to the host link.
REQ-009 SHALL have port out_valid, output, 1: out_data is valid.
REQ-010 SHALL have port out_ready, input, 1: the host accepts a byte.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-012 SHALL have port frame_done, output, 1: one-cycle pulse on acceptance of the trailer byte.

Function
REQ-013 SHALL implement states IDLE, HDR, CNT, DATA, CSUM, TRL and WAIT_CLR.
REQ-014 In IDLE with done=1, SHALL snapshot results and numResults in that cycle and enter HDR; out_valid is high on the next cycle.
REQ-015 The snapshot SHALL be used for the whole frame; input changes during a frame SHALL have no effect.
REQ-016 SHALL set the count to min(numResults, NUMRESULTS), clamping values that overflow.
REQ-017 SHALL send the frame bytes in this order:
- HDR: 0xA5
- CNT: count
- DATA: count slots, slot 1 first; within a slot m[0] first; each mark as {7'b0, bit8}, then bits7:0
- CSUM: checksum
- TRL: 0x5A
REQ-018 With count=0, SHALL go from CNT directly to CSUM (or to TRL when CSUM is compiled out).
REQ-019 A byte SHALL be accepted only on a cycle with out_valid=1 and out_ready=1; the next byte is presented in the following cycle, with no bubble.
REQ-020 While out_valid=1 and out_ready=0, out_data SHALL hold stable and out_valid SHALL stay high.
REQ-021 The byte and slot counters SHALL be sized for (NUMPOSITIONS+1)*2 bytes per slot and NUMRESULTS slots; the last DATA byte accepted moves to the next state.
REQ-022 After the trailer is accepted, SHALL pulse frame_done and enter WAIT_CLR; it SHALL return to IDLE only after done=0 is sampled, so one done assertion yields exactly one frame.
REQ-023 out_valid SHALL be 0 in IDLE and WAIT_CLR.

Reset
REQ-024 On a rising FXCLK edge with RESET_IN=1, SHALL force state=IDLE, out_valid=0, out_data=0x00, busy=0, frame_done=0, clear all counters and clear the checksum.
REQ-025 Reset mid-frame SHALL abort the frame; if done is still 1 after reset, a complete new frame starts from HDR.
REQ-026 RESET_IN SHALL take priority over a byte acceptance in the same cycle.

Configuration
REQ-027 With macro RESULT_FRAMER_CHECKSUM_EN defined, the CSUM state SHALL send the XOR of the count byte and all DATA bytes.
REQ-028 With RESULT_FRAMER_CHECKSUM_EN undefined, CSUM and its XOR register SHALL be absent, and the frame SHALL be exactly one byte shorter.

Verification
REQ-029 The bench SHALL cover, with checksum enabled:
- numResults=1, slot1=0,1,4,10,12,17, out_ready=1 -> A5 01 00 00 00 01 00 04 00 0A 00 0C 00 11 13 5A, then frame_done pulse.
- numResults=0 -> A5 00 00 5A; with checksum compiled out -> A5 00 5A.
- Mark value 300 in slot1 m[5] -> the mark's two bytes are 01 2C.
- numResults=12 -> count byte 0A; 124 bytes total; frame_done once; done held high sends no second frame until done drops and rises again.
- out_ready held 0 for 3 cycles at the 5th byte -> out_data and out_valid stable for those cycles, no byte lost or duplicated.
- RESET_IN=1 for one cycle mid-DATA with done=1 -> out_valid=0 the next cycle, then a full frame restarts at A5.

Source files
------------

// File: rtl/result_framer.sv
// rtl/result_framer.sv - frames a ruler-search result snapshot into a byte stream for the host link.
// Optional checksum byte before the trailer is enabled by defining RESULT_FRAMER_CHECKSUM_EN.
module result_framer #(
  parameter int NUMPOSITIONS = 5,
  parameter int NUMRESULTS   = 10
) (
  input  logic                                    FXCLK,
  input  logic                                    RESET_IN,
  input  logic                                    done,
  input  logic [5:0]                              numResults,
  input  logic [(NUMPOSITIONS+1)*9*NUMRESULTS-1:0] results,
  output logic [7:0]                              out_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic                                    busy,
  output logic                                    frame_done
);

  localparam int MARKS  = NUMPOSITIONS + 1;
  localparam int SLOT_W = MARKS * 9;
  localparam int RES_W  = SLOT_W * NUMRESULTS;
  localparam int BPS    = MARKS * 2;
  localparam int BW     = $clog2(BPS);
  localparam int SW     = (NUMRESULTS > 1) ? $clog2(NUMRESULTS) : 1;
  localparam int IW     = $clog2(RES_W);

  localparam logic [7:0]    HEADER    = 8'hA5;
  localparam logic [7:0]    TRAILER   = 8'h5A;
  localparam logic [7:0]    MAX_COUNT = 8'(NUMRESULTS);
  localparam logic [BW-1:0] LAST_BYTE = BW'(BPS - 1);

  typedef enum logic [2:0] {IDLE, HDR, CNT, DATA, CSUM, TRL, WAIT_CLR} state_t;

  state_t           state;
  logic [RES_W-1:0] snap;
  logic [7:0]       count;
  logic [BW-1:0]    byte_idx;
  logic [SW-1:0]    slot_idx;
`ifdef RESULT_FRAMER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  logic             accept;
  logic             last_data;
  logic [BW-1:0]    nxt_byte;
  logic [SW-1:0]    nxt_slot;
  int               sel_base;
  logic [IW-1:0]    sel_idx;
  logic [8:0]       mark;
  logic [7:0]       data_byte;

  assign accept    = out_valid && out_ready;
  assign last_data = (byte_idx == LAST_BYTE) && ((8'(slot_idx) + 8'd1) == count);

  // Look ahead to the byte that follows the one currently presented, so out_data stays registered.
  always_comb begin
    nxt_byte = '0;
    nxt_slot = '0;
    if (state == DATA) begin
      if (byte_idx != LAST_BYTE) begin
        nxt_byte = byte_idx + BW'(1);
        nxt_slot = slot_idx;
      end else begin
        nxt_slot = slot_idx + SW'(1);
      end
    end
    if (int'(nxt_slot) < NUMRESULTS)
      sel_base = (NUMRESULTS - 1 - int'(nxt_slot)) * SLOT_W + (MARKS - 1 - int'(nxt_byte) / 2) * 9;
    else
      sel_base = 0;
    sel_idx   = IW'(sel_base);
    mark      = snap[sel_idx +: 9];
    data_byte = nxt_byte[0] ? mark[7:0] : {7'b0, mark[8]};
  end

  always_ff @(posedge FXCLK) begin
    if (RESET_IN) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      count      <= 8'h00;
      byte_idx   <= '0;
      slot_idx   <= '0;
`ifdef RESULT_FRAMER_CHECKSUM_EN
      csum       <= 8'h00;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (done) begin
            snap      <= results;
            count     <= ({2'b00, numResults} > MAX_COUNT) ? MAX_COUNT : {2'b00, numResults};
            byte_idx  <= '0;
            slot_idx  <= '0;
            out_data  <= HEADER;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= HDR;
          end
        end
        HDR: begin
          if (accept) begin
            out_data <= count;
`ifdef RESULT_FRAMER_CHECKSUM_EN
            csum     <= count;
`endif
            state    <= CNT;
          end
        end
        CNT: begin
          if (accept) begin
            if (count == 8'h00) begin
`ifdef RESULT_FRAMER_CHECKSUM_EN
              out_data <= csum;
              state    <= CSUM;
`else
              out_data <= TRAILER;
              state    <= TRL;
`endif
            end else begin
              out_data <= data_byte;
              byte_idx <= '0;
              slot_idx <= '0;
              state    <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
`ifdef RESULT_FRAMER_CHECKSUM_EN
            csum <= csum ^ out_data;
`endif
            if (last_data) begin
              byte_idx <= '0;
              slot_idx <= '0;
`ifdef RESULT_FRAMER_CHECKSUM_EN
              out_data <= csum ^ out_data;
              state    <= CSUM;
`else
              out_data <= TRAILER;
              state    <= TRL;
`endif
            end else begin
              byte_idx <= nxt_byte;
              slot_idx <= nxt_slot;
              out_data <= data_byte;
            end
          end
        end
`ifdef RESULT_FRAMER_CHECKSUM_EN
        CSUM: begin
          if (accept) begin
            out_data <= TRAILER;
            state    <= TRL;
          end
        end
`endif
        TRL: begin
          if (accept) begin
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
            frame_done <= 1'b1;
            state      <= WAIT_CLR;
          end
        end
        WAIT_CLR: begin
          // Hold here until done drops so a single done level yields a single frame.
          if (!done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_framer.sv
// tb/tb_result_framer.sv - directed table-driven bench for result_framer; follows RESULT_FRAMER_CHECKSUM_EN.
module tb_result_framer;

  localparam int NP = 5;
  localparam int NR = 10;
  localparam int RW = (NP + 1) * 9 * NR;
`ifdef RESULT_FRAMER_CHECKSUM_EN
  localparam int BIG_LEN = 124;
`else
  localparam int BIG_LEN = 123;
`endif

  logic          FXCLK = 1'b0;
  logic          RESET_IN;
  logic          done;
  logic [5:0]    numResults;
  logic [RW-1:0] results;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          frame_done;

  always #5 FXCLK = ~FXCLK;

  result_framer #(.NUMPOSITIONS(NP), .NUMRESULTS(NR)) dut (
    .FXCLK(FXCLK), .RESET_IN(RESET_IN), .done(done), .numResults(numResults),
    .results(results), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .frame_done(frame_done)
  );

  typedef struct {
    string              name;
    logic [5:0]         nres;
    logic [0:5][8:0]    s1;
    logic [0:5][8:0]    s2;
    int                 blen;
    logic [0:25][7:0]   body;
    logic [7:0]         csum;
  } vec_t;

  vec_t       vecs[4];
  int         errors = 0;
  int         checks = 0;
  int         fd_cnt;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Collects accepted bytes until frame_done; optionally withholds out_ready at a given byte.
  task automatic collect(input int stall_at, input int stall_len, input int max_cyc);
    int         stalled = 0;
    bit         seen = 0;
    logic [7:0] held = 8'h00;
    got.delete();
    fd_cnt = 0;
    for (int c = 0; c < max_cyc && !seen; c++) begin
      @(negedge FXCLK);
      if (frame_done) begin
        fd_cnt++;
        seen = 1;
      end else begin
        if (stall_len > 0 && got.size() == stall_at && stalled < stall_len) begin
          if (stalled == 0) held = out_data;
          else check("stall_data", out_data, held);
          check("stall_valid", out_valid, 1);
          out_ready = 1'b0;
          stalled++;
        end else begin
          if (stall_len > 0 && stalled == stall_len && got.size() == stall_at)
            check("stall_release_data", out_data, held);
          out_ready = 1'b1;
        end
        if (out_valid && out_ready) got.push_back(out_data);
      end
    end
    if (!seen) check("frame_timeout", 0, 1);
    out_ready = 1'b1;
  endtask

  task automatic build_exp(input int idx);
    exp_q.delete();
    for (int i = 0; i < vecs[idx].blen; i++) exp_q.push_back(vecs[idx].body[i]);
`ifdef RESULT_FRAMER_CHECKSUM_EN
    exp_q.push_back(vecs[idx].csum);
`endif
    exp_q.push_back(8'h5A);
  endtask

  task automatic cmp_frame(input string name);
    check($sformatf("%s_len", name), got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_b%0d", name, i), got[i], exp_q[i]);
  endtask

  task automatic load_vec(input int idx);
    numResults = vecs[idx].nres;
    results    = {vecs[idx].s1, vecs[idx].s2, {((NR - 2) * 54){1'b0}}};
  endtask

  task automatic end_frame(input string name);
    done = 1'b0;
    @(negedge FXCLK);
    @(negedge FXCLK);
    check($sformatf("%s_idle_busy", name), busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0].name = "one_slot";
    vecs[0].nres = 6'd1;
    vecs[0].s1   = {9'd0, 9'd1, 9'd4, 9'd10, 9'd12, 9'd17};
    vecs[0].s2   = {6{9'd0}};
    vecs[0].blen = 14;
    vecs[0].body = {8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h04,
                    8'h00, 8'h0A, 8'h00, 8'h0C, 8'h00, 8'h11, {12{8'h00}}};
    vecs[0].csum = 8'h13;

    vecs[1].name = "zero_count";
    vecs[1].nres = 6'd0;
    vecs[1].s1   = {6{9'd7}};
    vecs[1].s2   = {6{9'd0}};
    vecs[1].blen = 2;
    vecs[1].body = {8'hA5, 8'h00, {24{8'h00}}};
    vecs[1].csum = 8'h00;

    vecs[2].name = "mark_300";
    vecs[2].nres = 6'd1;
    vecs[2].s1   = {9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd300};
    vecs[2].s2   = {6{9'd0}};
    vecs[2].blen = 14;
    vecs[2].body = {8'hA5, 8'h01, {10{8'h00}}, 8'h01, 8'h2C, {12{8'h00}}};
    vecs[2].csum = 8'h2C;

    vecs[3].name = "two_slots";
    vecs[3].nres = 6'd2;
    vecs[3].s1   = {9'd511, 9'd256, 9'd255, 9'd1, 9'd2, 9'd3};
    vecs[3].s2   = {9'd5, 9'd6, 9'd7, 9'd8, 9'd9, 9'd10};
    vecs[3].blen = 26;
    vecs[3].body = {8'hA5, 8'h02,
                    8'h01, 8'hFF, 8'h01, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03,
                    8'h00, 8'h05, 8'h00, 8'h06, 8'h00, 8'h07, 8'h00, 8'h08, 8'h00, 8'h09, 8'h00, 8'h0A};
    vecs[3].csum = 8'h0D;

    RESET_IN   = 1'b1;
    done       = 1'b0;
    out_ready  = 1'b1;
    numResults = 6'd0;
    results    = '0;
    repeat (3) @(posedge FXCLK);
    @(negedge FXCLK);
    RESET_IN = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);

    for (int i = 0; i < 4; i++) begin
      load_vec(i);
      done = 1'b1;
      collect(-1, 0, 200);
      check($sformatf("%s_fd", vecs[i].name), fd_cnt, 1);
      build_exp(i);
      cmp_frame(vecs[i].name);
      @(negedge FXCLK);
      check($sformatf("%s_fd_pulse", vecs[i].name), frame_done, 0);
      check($sformatf("%s_wait_valid", vecs[i].name), out_valid, 0);
      end_frame(vecs[i].name);
    end

    // Back-pressure at the fifth byte.
    load_vec(0);
    done = 1'b1;
    collect(4, 3, 200);
    build_exp(0);
    cmp_frame("stall");
    end_frame("stall");

    // Clamp to NUMRESULTS, single frame per done level.
    numResults = 6'd12;
    results    = {RW{1'b1}};
    done       = 1'b1;
    collect(-1, 0, 400);
    check("big_fd", fd_cnt, 1);
    check("big_len", got.size(), BIG_LEN);
    if (got.size() == BIG_LEN) begin
      check("big_count", got[1], 8'h0A);
      check("big_d0", got[2], 8'h01);
      check("big_d1", got[3], 8'hFF);
      check("big_trl", got[BIG_LEN-1], 8'h5A);
`ifdef RESULT_FRAMER_CHECKSUM_EN
      check("big_csum", got[BIG_LEN-2], 8'h0A);
`endif
    end
    begin
      int vcnt = 0;
      int fcnt = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge FXCLK);
        if (out_valid) vcnt++;
        if (frame_done) fcnt++;
      end
      check("hold_no_valid", vcnt, 0);
      check("hold_no_fd", fcnt, 0);
      check("hold_busy", busy, 1);
    end
    end_frame("big");
    out_ready = 1'b0;
    done      = 1'b1;
    @(negedge FXCLK);
    check("rearm_valid", out_valid, 1);
    check("rearm_data", out_data, 8'hA5);
    collect(-1, 0, 400);
    check("rearm_len", got.size(), BIG_LEN);
    end_frame("rearm");

    // Reset during DATA, with done still high and a byte being accepted.
    load_vec(3);
    got.delete();
    done = 1'b1;
    for (int c = 0; c < 50 && got.size() < 6; c++) begin
      @(negedge FXCLK);
      if (out_valid && out_ready) got.push_back(out_data);
    end
    check("pre_reset_bytes", got.size(), 6);
    RESET_IN = 1'b1;
    @(negedge FXCLK);
    RESET_IN  = 1'b0;
    out_ready = 1'b0;
    check("midrst_valid", out_valid, 0);
    check("midrst_data", out_data, 0);
    check("midrst_busy", busy, 0);
    @(negedge FXCLK);
    check("restart_valid", out_valid, 1);
    check("restart_data", out_data, 8'hA5);
    check("restart_busy", busy, 1);
    collect(-1, 0, 200);
    check("restart_fd", fd_cnt, 1);
    build_exp(3);
    cmp_frame("restart");
    end_frame("restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
